sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one sram-like memory port between the IF-stage instruction requester
//  and the EXE/MEM-stage data requester. Runs one transaction at a time:
//  arbitrate, address handshake, data handshake. Data has priority; a starvation
//  counter guarantees instruction-fetch progress. Sits between mycpu core and the
//  single-port memory/bridge.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width (wstrb width = DATA_W/8)
//  STARVE_LIMIT   4  consecutive data grants allowed while inst_req waits
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-high reset
//  inst_req      in   1       fetch request (read only)
//  inst_addr     in   ADDR_W  fetch address
//  inst_addr_ok  out  1       fetch request accepted
//  inst_data_ok  out  1       fetch data valid
//  inst_rdata    out  DATA_W  fetch data
//  data_req      in   1       load/store request
//  data_wr       in   1       1=store, 0=load
//  data_wstrb    in   DATA_W/8 byte strobes (stores)
//  data_addr     in   ADDR_W  load/store address
//  data_wdata    in   DATA_W  store data
//  data_addr_ok  out  1       load/store request accepted
//  data_data_ok  out  1       load data valid / store complete
//  data_rdata    out  DATA_W  load data
//  mem_req       out  1       downstream request
//  mem_wr        out  1       downstream write
//  mem_wstrb     out  DATA_W/8 downstream strobes (0 on reads)
//  mem_addr      out  ADDR_W  downstream address
//  mem_wdata     out  DATA_W  downstream write data
//  mem_addr_ok   in   1       downstream accepted request
//  mem_data_ok   in   1       downstream response
//  mem_rdata     in   DATA_W  downstream read data
// BEHAVIOUR
//  - FSM IDLE -> ADDR -> DATA -> IDLE; owner register (INST/DATA); starve counter.
//  - Reset: state=IDLE, owner=INST, starve=0; mem_req, mem_wr, mem_wstrb,
//    all *_addr_ok, *_data_ok = 0. *_rdata = mem_rdata always (qualified by data_ok).
//  - IDLE: if data_req && !(inst_req && starve==STARVE_LIMIT) grant DATA,
//    else if inst_req grant INST; registered, enters ADDR next cycle (1-cycle
//    arbitration bubble). No mem_req in IDLE.
//  - Starve: +1 on each DATA grant while inst_req=1 (saturate at LIMIT);
//    cleared on any INST grant or when inst_req=0 at a DATA grant.
//  - ADDR: mem_req = owner's req; mem_addr/wr/wstrb/wdata muxed combinationally
//    from owner's inputs (INST: wr=0, wstrb=0, wdata=0). Owner's addr_ok =
//    mem_addr_ok (other addr_ok=0). mem_req&&mem_addr_ok -> DATA.
//    Owner drops req before addr_ok -> IDLE, no transaction (flush cancel).
//  - DATA: mem_req=0. Owner's data_ok = mem_data_ok; on it -> IDLE. Stores also
//    receive data_ok. Earliest full transaction: 3 cycles (IDLE,ADDR,DATA).
//  - mem_data_ok outside DATA is ignored (no *_data_ok pulse).
//  - Non-owner requester sees addr_ok=0, data_ok=0 for the whole transaction;
//    requesters must hold req/fields stable until addr_ok.
//  - Reset mid-transaction: FSM to IDLE immediately; outstanding response is
//    dropped; downstream must be reset in the same cycle.
//  - Exactly one transaction outstanding; no pipelining of addr over data.
// TESTING
//  - Single fetch: inst_req, addr 0x1C000000, mem_addr_ok in ADDR, mem_data_ok
//    +2 cycles rdata 0x02800C0C -> inst_addr_ok one pulse, inst_data_ok with 0x02800C0C.
//  - Collision: inst_req & data_req (store, addr 0x80, wstrb 4'b0011,
//    wdata 0x1234) same cycle -> DATA granted first, mem_wr=1, mem_wstrb=4'b0011;
//    inst served next, mem_wstrb=0.
//  - Starvation: data_req held high with back-to-back loads, inst_req high ->
//    exactly 4 data transactions, then 1 inst, then data resumes.
//  - Backpressure: mem_addr_ok low 5 cycles in ADDR -> mem_req/addr stable,
//    no addr_ok to requester; mem_data_ok pulse in IDLE -> no data_ok.
//  - Cancel: owner drops inst_req in ADDR before mem_addr_ok -> IDLE next
//    cycle, mem_req=0, no data_ok.
//  - Reset in DATA state -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one sram-like memory port between the instruction-fetch requester
// and the load/store requester. One transaction is in flight at a time and
// walks IDLE -> ADDR -> DATA -> IDLE:
//   IDLE : arbitrate and register the winner (one-cycle arbitration bubble).
//   ADDR : forward the owner's request downstream until mem_addr_ok.
//   DATA : wait for mem_data_ok and hand it to the owner.
// Data requests win ties. A starvation counter forces an instruction grant
// once STARVE_LIMIT data grants were issued in a row while inst_req waited.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_req/inst_addr         fetch request (read only)
//   inst_addr_ok/inst_data_ok  fetch handshake responses, inst_rdata data
//   data_req/wr/wstrb/addr/wdata  load/store request
//   data_addr_ok/data_data_ok  load/store handshake responses, data_rdata data
//   mem_req/wr/wstrb/addr/wdata   downstream request (wstrb 0 on reads)
//   mem_addr_ok/mem_data_ok    downstream handshake, mem_rdata read data
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch side
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    // load/store side
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    // downstream memory port
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t           state_r;
    state_t           state_next_s;
    owner_t           owner_r;
    owner_t           owner_next_s;
    logic [CNT_W-1:0] starve_r;
    logic [CNT_W-1:0] starve_next_s;

    logic             starved_s;
    logic             grant_data_s;
    logic             grant_inst_s;
    logic             owner_req_s;

    // Arbitration: data wins unless the fetch side has waited through the limit.
    always_comb begin
        starved_s    = inst_req && (starve_r == STARVE_MAX);
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        if (state_r == ST_IDLE) begin
            grant_data_s = data_req && !starved_s;
            grant_inst_s = !grant_data_s && inst_req;
        end else begin
            grant_data_s = 1'b0;
            grant_inst_s = 1'b0;
        end
    end

    // Current owner's request line; a drop in ADDR cancels the transaction.
    always_comb begin
        owner_req_s = 1'b0;
        case (owner_r)
            OWN_DATA: owner_req_s = data_req;
            OWN_INST: owner_req_s = inst_req;
            default:  owner_req_s = 1'b0;
        endcase
    end

    // Next-state, owner and starvation-counter logic.
    always_comb begin
        state_next_s  = state_r;
        owner_next_s  = owner_r;
        starve_next_s = starve_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_data_s) begin
                    state_next_s = ST_ADDR;
                    owner_next_s = OWN_DATA;
                    // Count only grants that actually made the fetch side wait.
                    if (inst_req) begin
                        if (starve_r == STARVE_MAX) begin
                            starve_next_s = STARVE_MAX;
                        end else begin
                            starve_next_s = starve_r + CNT_W'(1);
                        end
                    end else begin
                        starve_next_s = {CNT_W{1'b0}};
                    end
                end else if (grant_inst_s) begin
                    state_next_s  = ST_ADDR;
                    owner_next_s  = OWN_INST;
                    starve_next_s = {CNT_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (!owner_req_s) begin
                    state_next_s = ST_IDLE;
                end else if (mem_addr_ok) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, owner and starvation registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            owner_r  <= OWN_INST;
            starve_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            owner_r  <= owner_next_s;
            starve_r <= starve_next_s;
        end
    end

    // Downstream request mux and requester handshakes, all derived from state.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wstrb    = {STRB_W{1'b0}};
        mem_addr     = {ADDR_W{1'b0}};
        mem_wdata    = {DATA_W{1'b0}};
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state_r)
            ST_ADDR: begin
                if (owner_r == OWN_DATA) begin
                    mem_req      = data_req;
                    mem_wr       = data_wr;
                    // Strobes are meaningless on loads; keep them quiet.
                    mem_wstrb    = data_wr ? data_wstrb : {STRB_W{1'b0}};
                    mem_addr     = data_addr;
                    mem_wdata    = data_wdata;
                    data_addr_ok = data_req && mem_addr_ok;
                end else begin
                    mem_req      = inst_req;
                    mem_addr     = inst_addr;
                    inst_addr_ok = inst_req && mem_addr_ok;
                end
            end
            ST_DATA: begin
                if (owner_r == OWN_DATA) begin
                    data_data_ok = mem_data_ok;
                end else begin
                    inst_data_ok = mem_data_ok;
                end
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Read data is broadcast; each side qualifies it with its own data_ok.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: fetch, collision, starvation,
// backpressure, cancel and mid-transaction reset.
module tb_sram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    sram_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] seq [8];
    int         n_seq;

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_seq       = 0;
        reset       = 1'b1;
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;

        // ---------------- reset state
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_mem_wr", mem_wr, 32'd0);
        chk("rst_mem_wstrb", mem_wstrb, 32'd0);
        chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 32'd0);

        // ---------------- single fetch
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        #1;
        chk("fetch_idle_no_req", mem_req, 32'd0);
        next_cycle();                               // ADDR, owner INST
        mem_addr_ok = 1'b1;
        #1;
        chk("fetch_mem_req", mem_req, 32'd1);
        chk("fetch_mem_addr", mem_addr, 32'h1C00_0000);
        chk("fetch_mem_wr", mem_wr, 32'd0);
        chk("fetch_addr_ok", inst_addr_ok, 32'd1);
        chk("fetch_other_addr_ok", data_addr_ok, 32'd0);
        next_cycle();                               // DATA
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        chk("fetch_data_no_req", mem_req, 32'd0);
        chk("fetch_addr_ok_pulse", inst_addr_ok, 32'd0);
        chk("fetch_no_early_data_ok", inst_data_ok, 32'd0);
        next_cycle();                               // still DATA
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0280_0C0C;
        #1;
        chk("fetch_data_ok", inst_data_ok, 32'd1);
        chk("fetch_rdata", inst_rdata, 32'h0280_0C0C);
        chk("fetch_other_data_ok", data_data_ok, 32'd0);
        next_cycle();                               // IDLE
        mem_data_ok = 1'b0;
        #1;
        chk("fetch_done_data_ok", inst_data_ok, 32'd0);

        // ---------------- collision: store wins, then fetch
        inst_req   = 1'b1;
        inst_addr  = 32'h1C00_0004;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h0000_0080;
        data_wdata = 32'h0000_1234;
        next_cycle();                               // ADDR, owner DATA
        mem_addr_ok = 1'b1;
        #1;
        chk("coll_mem_req", mem_req, 32'd1);
        chk("coll_mem_wr", mem_wr, 32'd1);
        chk("coll_mem_wstrb", mem_wstrb, 32'h3);
        chk("coll_mem_addr", mem_addr, 32'h80);
        chk("coll_mem_wdata", mem_wdata, 32'h1234);
        chk("coll_data_addr_ok", data_addr_ok, 32'd1);
        chk("coll_inst_addr_ok", inst_addr_ok, 32'd0);
        next_cycle();                               // DATA
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        chk("coll_store_data_ok", data_data_ok, 32'd1);
        chk("coll_inst_data_ok", inst_data_ok, 32'd0);
        next_cycle();                               // IDLE, grants INST
        mem_data_ok = 1'b0;
        next_cycle();                               // ADDR, owner INST
        mem_addr_ok = 1'b1;
        #1;
        chk("coll2_mem_addr", mem_addr, 32'h1C00_0004);
        chk("coll2_mem_wr", mem_wr, 32'd0);
        chk("coll2_mem_wstrb", mem_wstrb, 32'd0);
        chk("coll2_mem_wdata", mem_wdata, 32'd0);
        chk("coll2_inst_addr_ok", inst_addr_ok, 32'd1);
        next_cycle();                               // DATA
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hAABB_CCDD;
        #1;
        chk("coll2_inst_data_ok", inst_data_ok, 32'd1);
        chk("coll2_inst_rdata", inst_rdata, 32'hAABB_CCDD);
        next_cycle();                               // IDLE
        mem_data_ok = 1'b0;

        // ---------------- starvation: 4 loads, 1 fetch, loads resume
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0008;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_addr   = 32'h0000_0100;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            if (data_addr_ok && n_seq < 8) begin
                seq[n_seq] = 8'h44;
                n_seq++;
            end
            if (inst_addr_ok && n_seq < 8) begin
                seq[n_seq] = 8'h49;
                n_seq++;
            end
            next_cycle();
        end
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        chk("starve_grants", n_seq, 32'd6);
        chk("starve_g0", seq[0], 32'h44);
        chk("starve_g1", seq[1], 32'h44);
        chk("starve_g2", seq[2], 32'h44);
        chk("starve_g3", seq[3], 32'h44);
        chk("starve_g4_inst", seq[4], 32'h49);
        chk("starve_g5_resume", seq[5], 32'h44);

        // ---------------- backpressure in ADDR, stray data_ok in IDLE
        next_cycle();                               // settle in IDLE
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0010;
        next_cycle();                               // ADDR
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_mem_req", mem_req, 32'd1);
            chk("bp_mem_addr", mem_addr, 32'h1C00_0010);
            chk("bp_no_addr_ok", inst_addr_ok, 32'd0);
            next_cycle();
        end
        mem_addr_ok = 1'b1;
        #1;
        chk("bp_addr_ok", inst_addr_ok, 32'd1);
        next_cycle();                               // DATA
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        chk("bp_data_ok", inst_data_ok, 32'd1);
        next_cycle();                               // IDLE, mem_data_ok still high
        #1;
        chk("idle_stray_inst_data_ok", inst_data_ok, 32'd0);
        chk("idle_stray_data_data_ok", data_data_ok, 32'd0);
        next_cycle();
        mem_data_ok = 1'b0;

        // ---------------- cancel: fetch dropped in ADDR
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0020;
        next_cycle();                               // ADDR
        #1;
        chk("cancel_mem_req_before", mem_req, 32'd1);
        next_cycle();
        inst_req = 1'b0;
        #1;
        chk("cancel_mem_req_drop", mem_req, 32'd0);
        chk("cancel_addr_ok", inst_addr_ok, 32'd0);
        next_cycle();                               // IDLE
        mem_data_ok = 1'b1;
        #1;
        chk("cancel_idle_mem_req", mem_req, 32'd0);
        chk("cancel_no_data_ok", inst_data_ok, 32'd0);
        // a load must be granted next, proving the FSM returned to IDLE
        mem_data_ok = 1'b0;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_wstrb  = 4'hF;
        data_addr   = 32'h0000_0200;
        next_cycle();                               // ADDR, owner DATA
        mem_addr_ok = 1'b1;
        #1;
        chk("load_mem_addr", mem_addr, 32'h200);
        chk("load_mem_wstrb_zero", mem_wstrb, 32'd0);
        chk("load_addr_ok", data_addr_ok, 32'd1);
        next_cycle();                               // DATA

        // ---------------- reset while in DATA
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        reset       = 1'b1;
        next_cycle();                               // IDLE after reset
        reset       = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        chk("rstd_data_ok_dropped", data_data_ok, 32'd0);
        chk("rstd_inst_data_ok", inst_data_ok, 32'd0);
        chk("rstd_mem_req", mem_req, 32'd0);
        chk("rstd_mem_wr", mem_wr, 32'd0);
        chk("rstd_addr_ok", {inst_addr_ok, data_addr_ok}, 32'd0);
        next_cycle();
        mem_data_ok = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
